alarm_clock_core: RTL and testbench
===================================

Name: alarm_clock_core

Overview:
- Timekeeping and alarm stage directly downstream of the 1 s interval timer. It consumes that timer's one-cycle timeout pulse as `tick`.
- Holds BCD time-of-day (HH:MM:SS, 24 h) and a BCD alarm time (HH:MM). It runs a ring/snooze state machine.
- Exposes everything through a 16-bit Avalon-MM slave with an IRQ, plus BCD outputs for the display driver.

Parameters:
RING_SECONDS, 60, ticks spent in RINGING before auto-stop (1..127)
SNOOZE_MIN, 5, minute rollovers spent in SNOOZE before re-ring (1..127)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle 1 Hz pulse from upstream timer
address  in  3  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  16  write data
readdata  out  16  registered read data
irq  out  1  alarm interrupt
alarm_out  out  1  high while ringing (buzzer drive)
disp_hms  out  24  {hh,mm,ss} BCD, direct from time registers

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. Reset values:
  - time 00:00:00, alarm 00:00, CONTROL 0, STATUS 0;
  - state IDLE; readdata 0; irq 0; alarm_out 0.
- Register map. wr = chipselect & ~write_n. readdata = mux(address) registered, 1-cycle latency; unmapped addresses read 0.
  - 0 TIME_HM, R/W: [15:8] hh, [7:0] mm. A write also clears ss to 00.
  - 1 TIME_S, R/W: [7:0] ss; [15:8] read 0.
  - 2 ALARM_HM, R/W: [15:8] hh, [7:0] mm.
  - 3 CONTROL. Bits [2:0] are stored: bit0 alarm_en, bit1 irq_en, bit2 run. Bits 3–4 are self-clearing strobes that read 0: bit3 dismiss, bit4 snooze.
  - 4 STATUS. bit0 alarm_flag (W1C). bit1 ringing (read-only). bit2 err (W1C). bit3 snoozing (read-only).
- Validation:
  - hh valid iff both nibbles ≤ 9 and value ≤ 0x23. mm/ss valid iff tens ≤ 5 and units ≤ 9.
  - Any invalid field: the whole write is dropped, the register is unchanged and err is set.
- Counting:
  - A tick is accepted only when run=1.
  - Accepted tick: BCD increment ss. On 59→00, increment mm. On mm 59→00, increment hh. 23:59:59→00:00:00.
  - Same-cycle TIME_HM or TIME_S write and accepted tick: the write wins and the tick is discarded.
  - minute_roll = accepted tick with ss 59→00.
- Alarm match: minute_roll & alarm_en, with the new {hh,mm} equal to ALARM_HM.
  - Writing the time equal to the alarm never triggers a match.
- FSM states: IDLE, RINGING, SNOOZE.
  - IDLE → RINGING on match. On entry: load ring_cnt = RING_SECONDS and set alarm_flag.
  - RINGING:
    - Each accepted tick decrements ring_cnt; at 1→0, go to IDLE.
    - Dismiss → IDLE.
    - Snooze → SNOOZE, loading snz_cnt = SNOOZE_MIN.
    - A match while RINGING is ignored.
  - SNOOZE:
    - Each minute_roll decrements snz_cnt; at 1→0, go to RINGING (full re-entry, alarm_flag set again).
    - Dismiss → IDLE.
  - alarm_en=0, by write or at any time: forced to IDLE next cycle. alarm_flag is retained.
  - Dismiss and snooze written together: dismiss wins.
- Status bits:
  - W1C of alarm_flag in the same cycle as RINGING entry: set wins.
  - ringing = (state==RINGING); snoozing = (state==SNOOZE).
- Outputs:
  - alarm_out = ringing, registered from state with no extra delay.
  - irq = alarm_flag & irq_en, combinational.
- Reset mid-ring or mid-snooze: immediate return to IDLE with all registers at reset values.

Test Plan:
1. Increment and wrap: run=1, TIME_HM=0x2359, TIME_S=0x58, two ticks → disp_hms 0x235959 then 0x000000.
2. Invalid writes: write TIME_HM=0x2460 → TIME_HM still reads the old value, STATUS.err=1. Write STATUS=0x4 → err=0.
3. Alarm and auto-stop: ALARM_HM=0x0700, CONTROL=0x7, time 06:59:59, tick → alarm_out=1, STATUS=0x3, irq=1. RING_SECONDS=3, three more ticks → alarm_out=0, alarm_flag still 1.
4. Snooze: while ringing, write CONTROL=0x17 → SNOOZE, alarm_out=0. With SNOOZE_MIN=2, after 2 minute rollovers (07:02:00) → ringing again. Dismiss (CONTROL=0x0F) → IDLE.
5. Collision and run gating:
   - tick together with a TIME_S=0x30 write → ss=0x30, not 0x31.
   - run=0 with 5 ticks → time unchanged.
   - readdata valid exactly 1 cycle after address.
6. Reset while RINGING → alarm_out=0, irq=0, readdata=0, all registers read 0.

Source files
------------

// File: rtl/alarm_clock_core.sv
// BCD time-of-day and alarm core driven by the upstream 1 Hz tick.
// Exposes an Avalon-MM register slave, an IRQ, and BCD display outputs.
module alarm_clock_core #(
    parameter int unsigned RING_SECONDS = 60,
    parameter int unsigned SNOOZE_MIN   = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic        alarm_out,
    output logic [23:0] disp_hms
);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    localparam logic [6:0] RING_LOAD   = 7'(RING_SECONDS);
    localparam logic [6:0] SNOOZE_LOAD = 7'(SNOOZE_MIN);

    state_t      state;
    logic [7:0]  hh, mm, ss;
    logic [7:0]  al_hh, al_mm;
    logic [2:0]  ctrl;
    logic        alarm_flag;
    logic        err;
    logic [6:0]  ring_cnt;
    logic [6:0]  snz_cnt;

    logic        wr, wr_hm, wr_s, wr_al, wr_ctl, wr_st;
    logic        hm_ok, s_ok, al_ok, err_set;
    logic        alarm_en, irq_en, run;
    logic        time_wr, acc_tick, sec_wrap, min_wrap, minute_roll, match;
    logic        dismiss, snooze, en_nxt;
    logic [7:0]  ss_inc, mm_inc, hh_inc, mm_n, hh_n;
    logic        ringing, snoozing;

    function automatic logic hh_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= 8'h23);
    endfunction

    function automatic logic ms_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return v + 8'd1;
    endfunction

    assign alarm_en = ctrl[0];
    assign irq_en   = ctrl[1];
    assign run      = ctrl[2];

    assign wr     = chipselect & ~write_n;
    assign wr_hm  = wr & (address == 3'd0);
    assign wr_s   = wr & (address == 3'd1);
    assign wr_al  = wr & (address == 3'd2);
    assign wr_ctl = wr & (address == 3'd3);
    assign wr_st  = wr & (address == 3'd4);

    assign hm_ok   = hh_valid(writedata[15:8]) & ms_valid(writedata[7:0]);
    assign s_ok    = ms_valid(writedata[7:0]);
    assign al_ok   = hm_ok;
    assign err_set = (wr_hm & ~hm_ok) | (wr_s & ~s_ok) | (wr_al & ~al_ok);

    // A valid time write takes priority; the coincident tick is discarded entirely.
    assign time_wr  = (wr_hm & hm_ok) | (wr_s & s_ok);
    assign acc_tick = tick & run & ~time_wr;

    assign ss_inc   = bcd_inc(ss, 8'h59);
    assign mm_inc   = bcd_inc(mm, 8'h59);
    assign hh_inc   = bcd_inc(hh, 8'h23);
    assign sec_wrap = (ss == 8'h59);
    assign min_wrap = (mm == 8'h59);
    assign mm_n     = sec_wrap ? mm_inc : mm;
    assign hh_n     = (sec_wrap && min_wrap) ? hh_inc : hh;

    assign minute_roll = acc_tick & sec_wrap;
    assign match       = minute_roll & alarm_en & (hh_n == al_hh) & (mm_n == al_mm);

    assign dismiss = wr_ctl & writedata[3];
    assign snooze  = wr_ctl & writedata[4];
    assign en_nxt  = wr_ctl ? writedata[0] : alarm_en;

    assign ringing  = (state == RINGING);
    assign snoozing = (state == SNOOZE);

    assign irq      = alarm_flag & irq_en;
    assign disp_hms = {hh, mm, ss};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hh <= '0;
            mm <= '0;
            ss <= '0;
        end else if (wr_hm && hm_ok) begin
            hh <= writedata[15:8];
            mm <= writedata[7:0];
            ss <= '0;
        end else if (wr_s && s_ok) begin
            ss <= writedata[7:0];
        end else if (acc_tick) begin
            ss <= ss_inc;
            mm <= mm_n;
            hh <= hh_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            al_hh <= '0;
            al_mm <= '0;
            ctrl  <= '0;
            err   <= 1'b0;
        end else begin
            if (wr_al && al_ok) begin
                al_hh <= writedata[15:8];
                al_mm <= writedata[7:0];
            end
            if (wr_ctl)
                ctrl <= writedata[2:0];
            if (err_set)
                err <= 1'b1;
            else if (wr_st && writedata[2])
                err <= 1'b0;
        end
    end

    // W1C is applied first so that a same-cycle ring entry re-sets the flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            alarm_out  <= 1'b0;
            alarm_flag <= 1'b0;
            ring_cnt   <= '0;
            snz_cnt    <= '0;
        end else begin
            if (wr_st && writedata[0])
                alarm_flag <= 1'b0;
            if (!en_nxt) begin
                state     <= IDLE;
                alarm_out <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (match) begin
                            state      <= RINGING;
                            alarm_out  <= 1'b1;
                            ring_cnt   <= RING_LOAD;
                            alarm_flag <= 1'b1;
                        end
                    end
                    RINGING: begin
                        if (dismiss) begin
                            state     <= IDLE;
                            alarm_out <= 1'b0;
                        end else if (snooze) begin
                            state     <= SNOOZE;
                            alarm_out <= 1'b0;
                            snz_cnt   <= SNOOZE_LOAD;
                        end else if (acc_tick) begin
                            if (ring_cnt <= 7'd1) begin
                                state     <= IDLE;
                                alarm_out <= 1'b0;
                            end else begin
                                ring_cnt <= ring_cnt - 7'd1;
                            end
                        end
                    end
                    SNOOZE: begin
                        if (dismiss) begin
                            state <= IDLE;
                        end else if (minute_roll) begin
                            if (snz_cnt <= 7'd1) begin
                                state      <= RINGING;
                                alarm_out  <= 1'b1;
                                ring_cnt   <= RING_LOAD;
                                alarm_flag <= 1'b1;
                            end else begin
                                snz_cnt <= snz_cnt - 7'd1;
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        alarm_out <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            unique case (address)
                3'd0:    readdata <= {hh, mm};
                3'd1:    readdata <= {8'h00, ss};
                3'd2:    readdata <= {al_hh, al_mm};
                3'd3:    readdata <= {13'h0, ctrl};
                3'd4:    readdata <= {12'h0, snoozing, err, ringing, alarm_flag};
                default: readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_clock_core.sv
// Scoreboard bench for alarm_clock_core: directed stimulus pushes expectations,
// a negedge monitor pops and compares when a sample is presented.
module tb_alarm_clock_core;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;
    logic        alarm_out;
    logic [23:0] disp_hms;

    alarm_clock_core #(.RING_SECONDS(3), .SNOOZE_MIN(2)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq), .alarm_out(alarm_out), .disp_hms(disp_hms)
    );

    always #5 clk = ~clk;

    localparam int K_RD = 0, K_DISP = 1, K_ALM = 2, K_IRQ = 3;

    typedef struct {
        int          kind;
        logic [23:0] exp;
        string       name;
    } chk_t;

    chk_t sbq[$];
    chk_t cur;
    logic chk_req = 1'b0;
    logic chk_v = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;
    logic [23:0] act;

    always @(posedge clk) chk_v <= chk_req;

    always @(negedge clk) begin
        if (chk_v) begin
            if (sbq.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_sample: no expectation queued");
            end else begin
                cur = sbq.pop_front();
                case (cur.kind)
                    K_RD:    act = {8'h00, readdata};
                    K_DISP:  act = disp_hms;
                    K_ALM:   act = {23'h0, alarm_out};
                    default: act = {23'h0, irq};
                endcase
                n_run++;
                if (act !== cur.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
                end
            end
        end
    end

    task automatic push(input int kind, input logic [23:0] exp, input string name);
        chk_t c;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        sbq.push_back(c);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic wr_tick(input logic [2:0] a, input logic [15:0] d);
        tick = 1'b1;
        wr(a, d);
        tick = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic chk_rd(input logic [2:0] a, input logic [15:0] exp, input string name);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        push(K_RD, {8'h00, exp}, name);
        chk_req = 1'b1;
        @(negedge clk);
        chk_req = 1'b0; chipselect = 1'b0;
    endtask

    task automatic chk_pin(input int kind, input logic [23:0] exp, input string name);
        push(kind, exp, name);
        chk_req = 1'b1;
        @(negedge clk);
        chk_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // reset state
        chk_rd(3'd0, 16'h0000, "rst_time_hm");
        chk_rd(3'd1, 16'h0000, "rst_time_s");
        chk_rd(3'd2, 16'h0000, "rst_alarm_hm");
        chk_rd(3'd3, 16'h0000, "rst_control");
        chk_rd(3'd4, 16'h0000, "rst_status");
        chk_pin(K_DISP, 24'h000000, "rst_disp");
        chk_pin(K_ALM, 24'h0, "rst_alarm_out");
        chk_pin(K_IRQ, 24'h0, "rst_irq");

        // increment and wrap
        wr(3'd3, 16'h0004);
        wr(3'd0, 16'h2359);
        wr(3'd1, 16'h0058);
        do_tick();
        chk_pin(K_DISP, 24'h235959, "inc_235959");
        do_tick();
        chk_pin(K_DISP, 24'h000000, "wrap_000000");
        chk_rd(3'd0, 16'h0000, "wrap_time_hm");

        // invalid writes
        wr(3'd0, 16'h1234);
        wr(3'd0, 16'h2460);
        chk_rd(3'd0, 16'h1234, "inv_hm_kept");
        chk_rd(3'd4, 16'h0004, "inv_err_set");
        wr(3'd4, 16'h0004);
        chk_rd(3'd4, 16'h0000, "err_w1c");
        wr(3'd1, 16'h005A);
        chk_rd(3'd1, 16'h0000, "inv_ss_kept");
        wr(3'd4, 16'h0004);
        wr(3'd2, 16'h1A00);
        chk_rd(3'd2, 16'h0000, "inv_alarm_kept");
        chk_rd(3'd4, 16'h0004, "inv_alarm_err");
        wr(3'd4, 16'h0004);

        // alarm and auto-stop
        wr(3'd2, 16'h0700);
        wr(3'd3, 16'h0007);
        wr(3'd0, 16'h0659);
        wr(3'd1, 16'h0059);
        do_tick();
        chk_pin(K_ALM, 24'h1, "ring_alarm_out");
        chk_rd(3'd4, 16'h0003, "ring_status");
        chk_pin(K_IRQ, 24'h1, "ring_irq");
        chk_pin(K_DISP, 24'h070000, "ring_disp");
        do_tick();
        do_tick();
        chk_pin(K_ALM, 24'h1, "ring_after_2");
        do_tick();
        chk_pin(K_ALM, 24'h0, "autostop_alarm_out");
        chk_rd(3'd4, 16'h0001, "autostop_flag_kept");
        chk_pin(K_DISP, 24'h070003, "autostop_disp");

        // snooze cycle
        wr(3'd4, 16'h0001);
        chk_rd(3'd4, 16'h0000, "flag_w1c");
        chk_pin(K_IRQ, 24'h0, "irq_cleared");
        wr(3'd2, 16'h0800);
        wr(3'd0, 16'h0759);
        wr(3'd1, 16'h0059);
        do_tick();
        chk_rd(3'd4, 16'h0003, "ring2_status");
        wr(3'd3, 16'h0017);
        chk_pin(K_ALM, 24'h0, "snooze_alarm_out");
        chk_rd(3'd4, 16'h0009, "snooze_status");
        chk_rd(3'd3, 16'h0007, "strobes_read_0");
        wr(3'd1, 16'h0059);
        do_tick();
        chk_rd(3'd4, 16'h0009, "snooze_1_roll");
        wr(3'd4, 16'h0001);
        chk_rd(3'd4, 16'h0008, "snooze_flag_clr");
        wr(3'd1, 16'h0059);
        do_tick();
        chk_pin(K_ALM, 24'h1, "rering_alarm_out");
        chk_rd(3'd4, 16'h0003, "rering_status");
        chk_pin(K_DISP, 24'h080200, "rering_disp");
        wr(3'd3, 16'h000F);
        chk_rd(3'd4, 16'h0001, "dismiss_status");
        chk_pin(K_ALM, 24'h0, "dismiss_alarm_out");

        // dismiss beats snooze; alarm_en=0 forces idle
        wr(3'd0, 16'h0759);
        wr(3'd1, 16'h0059);
        do_tick();
        chk_rd(3'd4, 16'h0003, "ring3_status");
        wr(3'd3, 16'h001F);
        chk_rd(3'd4, 16'h0001, "dismiss_wins");
        wr(3'd0, 16'h0759);
        wr(3'd1, 16'h0059);
        do_tick();
        wr(3'd3, 16'h0006);
        chk_rd(3'd4, 16'h0001, "en_off_idle");
        chk_pin(K_ALM, 24'h0, "en_off_alarm_out");
        wr(3'd3, 16'h0007);

        // collision and run gating
        wr(3'd0, 16'h1000);
        wr_tick(3'd1, 16'h0030);
        chk_pin(K_DISP, 24'h100030, "collision_disp");
        chk_rd(3'd1, 16'h0030, "collision_ss");
        wr(3'd3, 16'h0003);
        repeat (5) do_tick();
        chk_pin(K_DISP, 24'h100030, "run0_hold");

        // reset while ringing
        wr(3'd3, 16'h0007);
        wr(3'd2, 16'h1100);
        wr(3'd0, 16'h1059);
        wr(3'd1, 16'h0059);
        do_tick();
        chk_pin(K_ALM, 24'h1, "pre_rst_ring");
        chk_pin(K_IRQ, 24'h1, "pre_rst_irq");
        reset_n = 1'b0;
        chk_pin(K_ALM, 24'h0, "in_rst_alarm_out");
        chk_pin(K_IRQ, 24'h0, "in_rst_irq");
        chk_rd(3'd0, 16'h0000, "in_rst_readdata");
        reset_n = 1'b1;
        @(negedge clk);
        chk_rd(3'd0, 16'h0000, "post_rst_time_hm");
        chk_rd(3'd1, 16'h0000, "post_rst_time_s");
        chk_rd(3'd2, 16'h0000, "post_rst_alarm_hm");
        chk_rd(3'd3, 16'h0000, "post_rst_control");
        chk_rd(3'd4, 16'h0000, "post_rst_status");
        chk_pin(K_DISP, 24'h000000, "post_rst_disp");

        for (int i = 0; i < 5 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
